// File: rtl/parallel_to_serial_rf.sv
// Packed-word to element-stream converter, element 0 first, valid/ready both sides.
// Optional build macro P2S_IDLE_POISON_EN drives a dummy value on out while idle.
module parallel_to_serial_rf #(
   parameter int WIDTH = 1,
   parameter int N_INS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_INS*WIDTH-1:0] in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out,
   output logic                   out_last
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [31:0] LAST = 32'(N_INS - 1);

   state_t                 state, state_nx;
   logic [31:0]            idx, idx_nx;
   logic [N_INS*WIDTH-1:0] data, data_nx;
   logic [WIDTH-1:0]       elem;
   logic                   beat;
   logic                   load;

   assign out_valid = (state == SEND);
   assign out_last  = out_valid & (idx == LAST);
   assign beat      = out_valid & out_ready;
   // gated by rst so the producer never sees ready while held in reset
   assign in_ready  = rst & ((state == IDLE) | (beat & out_last));
   assign load      = in_valid & in_ready;
   assign elem      = data[WIDTH*idx +: WIDTH];

`ifdef P2S_IDLE_POISON_EN
   localparam logic [WIDTH-1:0] POISON = WIDTH'(189);
   assign out = out_valid ? elem : POISON;
`else
   assign out = elem;
`endif

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      data_nx  = data;
      unique case (state)
         IDLE: ;
         SEND: begin
            if (beat) begin
               if (out_last) state_nx = IDLE;
               else          idx_nx   = idx + 32'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // a load on the last beat overrides the return to IDLE
      if (load) begin
         state_nx = SEND;
         idx_nx   = '0;
         data_nx  = in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         idx   <= '0;
         data  <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         data  <= data_nx;
      end
   end

endmodule

// File: tb/tb_parallel_to_serial_rf.sv
// Bench for parallel_to_serial_rf: 8x4 instance plus a 4x1 instance.
module tb_parallel_to_serial_rf;

   typedef struct {
      logic [31:0]      word;
      logic [0:3][7:0]  exp;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       last;
   } sb_t;

`ifdef P2S_IDLE_POISON_EN
   localparam logic [7:0] RST_A  = 8'hBD;
   localparam logic [7:0] IDLE_A = 8'hBD;
   localparam logic [3:0] IDLE_B = 4'hD;
`else
   localparam logic [7:0] RST_A  = 8'h00;
   localparam logic [7:0] IDLE_A = 8'h44;
   localparam logic [3:0] IDLE_B = 4'h9;
`endif

   logic        clk;
   logic        rst;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
   logic [31:0] a_in;
   logic [7:0]  a_out;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [3:0]  b_in;
   logic [3:0]  b_out;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t vt [5];
   sb_t  sb [$];

   parallel_to_serial_rf #(.WIDTH(8), .N_INS(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out(a_out), .out_last(a_out_last)
   );

   parallel_to_serial_rf #(.WIDTH(4), .N_INS(1)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out(b_out), .out_last(b_out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // consumer-side scoreboard for the 8x4 instance
   always @(negedge clk) begin
      if (rst && a_out_valid && a_out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL a_beat: got unexpected %h expected none", a_out);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("a_out", {24'd0, a_out}, {24'd0, e.d});
            check("a_last", {31'd0, a_out_last}, {31'd0, e.last});
         end
      end
   end

   // call at posedge+1; returns after the load edge (+1), in_valid left high
   task automatic send(input vec_t v, output int n);
      a_in_valid = 1'b1;
      a_in       = v.word;
      n          = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!a_in_ready && n < 50);
      if (!a_in_ready) begin
         check("send_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk);
         for (int i = 0; i < 4; i++)
            sb.push_back('{d: v.exp[i], last: (i == 3)});
         #1;
      end
   endtask

   task automatic drain();
      a_out_ready = 1'b1;
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      check("drain_empty", sb.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int        n;
      int        bb;
      logic      pat [7];
      logic [3:0] bv [3];

      vt[0].word = 32'h44332211; vt[0].exp = {8'h11, 8'h22, 8'h33, 8'h44};
      vt[1].word = 32'h88776655; vt[1].exp = {8'h55, 8'h66, 8'h77, 8'h88};
      vt[2].word = 32'hDEADBEEF; vt[2].exp = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      vt[3].word = 32'h00FF807F; vt[3].exp = {8'h7F, 8'h80, 8'hFF, 8'h00};
      vt[4].word = 32'hDDCCBBAA; vt[4].exp = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      bv  = '{4'd3, 4'd5, 4'd9};

      rst = 1'b0;
      a_in_valid = 1'b0; a_in = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in = '0; b_out_ready = 1'b1;

      // reset state
      #1;
      check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
      check("rst_out_last", {31'd0, a_out_last}, 32'd0);
      check("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
      check("rst_out", {24'd0, a_out}, {24'd0, RST_A});
      #11;
      rst = 1'b1;
      a_out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
      check("post_rst_valid", {31'd0, a_out_valid}, 32'd0);
      @(posedge clk);
      #1;

      // single word, cycle-exact
      send(vt[0], n);
      a_in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("single_valid", {31'd0, a_out_valid}, 32'd1);
         check("single_out", {24'd0, a_out}, {24'd0, vt[0].exp[j]});
         check("single_last", {31'd0, a_out_last}, (j == 3) ? 32'd1 : 32'd0);
         check("single_in_ready", {31'd0, a_in_ready}, (j == 3) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      check("single_idle_ready", {31'd0, a_in_ready}, 32'd1);
      check("single_idle_valid", {31'd0, a_out_valid}, 32'd0);
      check("single_idle_out", {24'd0, a_out}, {24'd0, IDLE_A});
      @(posedge clk);
      #1;

      // backpressure
      send(vt[0], n);
      a_in_valid = 1'b0;
      bb = 0;
      for (int j = 0; j < 7; j++) begin
         a_out_ready = pat[j];
         @(negedge clk);
         check("bp_valid", {31'd0, a_out_valid}, 32'd1);
         check("bp_out", {24'd0, a_out}, {24'd0, vt[0].exp[bb]});
         check("bp_in_ready", {31'd0, a_in_ready},
               (pat[j] && bb == 3) ? 32'd1 : 32'd0);
         if (pat[j]) bb++;
         @(posedge clk);
         #1;
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      check("bp_done_valid", {31'd0, a_out_valid}, 32'd0);
      @(posedge clk);
      #1;

      // back-to-back stream from the table
      for (int i = 0; i < 4; i++) begin
         send(vt[i], n);
         check("b2b_wait", n, (i == 0) ? 32'd1 : 32'd4);
      end
      a_in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("b2b_tail_valid", {31'd0, a_out_valid}, 32'd1);
      end
      @(negedge clk);
      check("b2b_end_valid", {31'd0, a_out_valid}, 32'd0);
      drain();

      // single-element words on the 4x1 instance
      for (int i = 0; i < 4; i++) begin
         b_in_valid = (i < 3);
         b_in       = (i < 3) ? bv[i] : 4'd0;
         @(negedge clk);
         check("n1_in_ready", {31'd0, b_in_ready}, 32'd1);
         if (i > 0) begin
            check("n1_valid", {31'd0, b_out_valid}, 32'd1);
            check("n1_out", {28'd0, b_out}, {28'd0, bv[i-1]});
            check("n1_last", {31'd0, b_out_last}, 32'd1);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("n1_idle_valid", {31'd0, b_out_valid}, 32'd0);
      check("n1_idle_out", {28'd0, b_out}, {28'd0, IDLE_B});
      @(posedge clk);
      #1;

      // reset during the second beat of a word
      send(vt[0], n);
      a_in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_valid", {31'd0, a_out_valid}, 32'd0);
      check("midrst_last", {31'd0, a_out_last}, 32'd0);
      check("midrst_in_ready", {31'd0, a_in_ready}, 32'd0);
      check("midrst_out", {24'd0, a_out}, {24'd0, RST_A});
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_rel_ready", {31'd0, a_in_ready}, 32'd1);
      check("midrst_rel_valid", {31'd0, a_out_valid}, 32'd0);
      @(posedge clk);
      #1;
      send(vt[4], n);
      a_in_valid = 1'b0;
      @(negedge clk);
      check("midrst_first", {24'd0, a_out}, 32'h000000AA);
      drain();
      @(negedge clk);
      check("final_idle", {31'd0, a_out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/parallel_to_serial_rf.md
# parallel_to_serial_rf

Transmit-side counterpart to the serial-to-parallel register file: accepts one packed word of N_INS elements, each WIDTH bits wide, and emits them one element per accepted beat, element 0 (bits [WIDTH-1:0]) first. It sits between a wide producer, such as an SRAM read port or compute result, and a narrow serial consumer. Both sides use a valid/ready handshake, and back-to-back words stream with no bubble.

## Interface
Parameters:
- WIDTH, 1, bits per element.
- N_INS, 2, elements per packed word; must be ≥ 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a packed word on `in`.
- in_ready  output  1  block can accept `in` this cycle.
- in  input  N_INS*WIDTH  packed word; element i is `in[WIDTH*i +: WIDTH]`.
- out_valid  output  1  `out` holds a valid element.
- out_ready  input  1  consumer accepts `out` this cycle.
- out  output  WIDTH  current element.
- out_last  output  1  current element is element N_INS-1 of its word.

## Operation
- State:
  - FSM IDLE/SEND.
  - Data register `data` (N_INS*WIDTH).
  - 32-bit element index `idx`.
- Load: a load occurs when in_valid & in_ready at posedge. It does `data <= in`, `idx <= 0`, FSM → SEND.
- Beat: a beat is accepted when out_valid & out_ready at posedge.
  - If idx < N_INS-1: `idx <= idx+1`.
  - If idx == N_INS-1 (last beat): FSM → IDLE, unless a load occurs in the same cycle, in which case the load wins (SEND, idx=0, new data).
- Outputs:
  - out_valid = (FSM == SEND).
  - out = `data[WIDTH*idx +: WIDTH]`.
  - out_last = out_valid & (idx == N_INS-1).
- in_ready = (FSM == IDLE) | (out_valid & out_ready & out_last). This is combinational from out_ready.
- In SEND with out_ready=0, all state holds. `in` is ignored unless a load occurs.
- N_INS=1: every beat is last. A word loaded each cycle gives out_valid continuously high.
- `data` is not modified except on a load.

## Timing
- Reset (rst=0, async):
  - FSM=IDLE, idx=0, data=0.
  - out_valid=0, out_last=0, in_ready=0 while rst is low.
  - in_ready=1 from the first cycle after rst rises.
- Latency: a load at edge k gives out_valid=1 with element 0 on out after edge k, in cycle k+1.
- Throughput: one element per cycle while out_ready=1. A word occupies exactly N_INS beats.
- Back-to-back: the next word can load in the same cycle as the last beat, so element 0 of word n+1 follows element N_INS-1 of word n with zero gap.
- in_ready is 0 during non-last beats of SEND. The producer must hold in_valid and in stable until in_ready is seen.
- Reset asserted mid-word: the remaining elements are discarded and outputs drop to reset values immediately (asynchronous). No partial word is replayed after reset.

## Configuration
- Macro: P2S_IDLE_POISON_EN.
- Defined: while out_valid=0, out = 189 truncated to WIDTH bits. This is a dummy value to make consumer sampling errors obvious.
- Undefined: out always equals `data[WIDTH*idx +: WIDTH]`.
  - This is 0 after reset.
  - In IDLE after a completed word it is `data[WIDTH*idx +: WIDTH]` at the final idx (N_INS-1), i.e. the last element of the last word.
- Handshake behaviour and out_last are identical in both builds.

## Test plan
- Reset then single word: WIDTH=8, N_INS=4, in=0x44332211 with out_ready=1.
  - Load edge k.
  - out = 0x11,0x22,0x33,0x44 in cycles k+1..k+4.
  - out_last only at 0x44.
  - in_ready=1 at k+4 and k+5.
- Backpressure: same word, out_ready toggled 1,0,0,1,1,0,1.
  - Exactly 4 beats are delivered in order, with no duplicates.
  - out and idx hold during out_ready=0.
  - in_ready=0 until the last-beat cycle.
- Back-to-back: words 0x44332211 then 0x88776655 presented with in_valid=1 continuously, out_ready=1.
  - 8 consecutive valid cycles: 0x11..0x44, 0x55..0x88.
  - Second load coincides with the 0x44 beat.
- N_INS=1, WIDTH=4: stream in = 3,5,9 on consecutive cycles.
  - out = 3,5,9 on consecutive cycles.
  - out_last=1 every valid cycle.
  - in_ready stays 1.
- Mid-word reset: WIDTH=8, N_INS=4, word 0x44332211 loaded.
  - Pull rst low during the 0x22 beat (after 0x11 accepted).
  - out_valid drops to 0 immediately.
  - After release, in_ready=1, out_valid=0.
  - Next word 0xDDCCBBAA emits 0xAA first.
- Idle value: WIDTH=8.
  - With P2S_IDLE_POISON_EN, out=189 (0xBD) after reset and between words.
  - Without it, out=0 after reset.
  - Without it, after word 0x44332211 completes, out=0x44 while idle.
